// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - alarm ring/snooze controller fed by the BCD clock and alarm values
module alarm_ctrl #(
    parameter int TICK_DIV   = 100000000,
    parameter int BEEP_DIV   = 12500000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] clock_in,
    input  logic [15:0] alarm_in,
    input  logic        alarm_en,
    input  logic        clock_load,
    input  logic        stop_btn,
    input  logic        snooze_btn,
    output logic        buzz,
    output logic        ringing,
    output logic        snoozing,
    output logic [1:0]  snooze_cnt
);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BEEP_W = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;
    localparam int RSEC_W = (RING_SEC > 0) ? $clog2(RING_SEC + 1) : 1;
    localparam int MIN_W  = (SNOOZE_MIN > 0) ? $clog2(SNOOZE_MIN + 1) : 1;

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    state_t            state, state_d;
    logic              buzz_d;
    logic [1:0]        snooze_cnt_d;
    logic [RSEC_W-1:0] ring_sec, ring_sec_d;
    logic [MIN_W-1:0]  min_left, min_left_d;
    logic [BEEP_W-1:0] beep_cnt, beep_cnt_d;
    logic [TICK_W-1:0] tick_cnt;
    logic [15:0]       clock_q;
    logic              clock_valid;
    logic [2:0]        stop_sync, snooze_sync;

    logic stop_p, snooze_p, sec_tick, min_evt, match_evt;

    assign stop_p    = stop_sync[1] & ~stop_sync[2];
    assign snooze_p  = snooze_sync[1] & ~snooze_sync[2];
    assign sec_tick  = (tick_cnt == TICK_W'(TICK_DIV - 1));
    // clock_valid masks the first edge after reset, when clock_q still holds zero
    assign min_evt   = clock_valid && (clock_in != clock_q) && !clock_load;
    assign match_evt = min_evt && (clock_in == alarm_in) && alarm_en;

    assign ringing  = (state == RING);
    assign snoozing = (state == SNOOZE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stop_sync   <= '0;
            snooze_sync <= '0;
            tick_cnt    <= '0;
            clock_q     <= '0;
            clock_valid <= 1'b0;
        end else begin
            stop_sync   <= {stop_sync[1:0], stop_btn};
            snooze_sync <= {snooze_sync[1:0], snooze_btn};
            tick_cnt    <= sec_tick ? '0 : tick_cnt + TICK_W'(1);
            clock_q     <= clock_in;
            clock_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            buzz       <= 1'b0;
            snooze_cnt <= '0;
            ring_sec   <= '0;
            min_left   <= '0;
            beep_cnt   <= '0;
        end else begin
            state      <= state_d;
            buzz       <= buzz_d;
            snooze_cnt <= snooze_cnt_d;
            ring_sec   <= ring_sec_d;
            min_left   <= min_left_d;
            beep_cnt   <= beep_cnt_d;
        end
    end

    always_comb begin
        state_d      = state;
        buzz_d       = buzz;
        snooze_cnt_d = snooze_cnt;
        ring_sec_d   = ring_sec;
        min_left_d   = min_left;
        beep_cnt_d   = beep_cnt;
        case (state)
            IDLE: begin
                buzz_d       = 1'b0;
                snooze_cnt_d = '0;
                if (match_evt) begin
                    state_d    = RING;
                    ring_sec_d = '0;
                    beep_cnt_d = '0;
                    buzz_d     = 1'b1;
                end
            end
            RING: begin
                if (!alarm_en || stop_p) begin
                    state_d      = IDLE;
                    buzz_d       = 1'b0;
                    snooze_cnt_d = '0;
                end else if (snooze_p && (snooze_cnt < 2'(MAX_SNOOZE))) begin
                    state_d      = SNOOZE;
                    snooze_cnt_d = snooze_cnt + 2'd1;
                    min_left_d   = MIN_W'(SNOOZE_MIN);
                    buzz_d       = 1'b0;
                end else if (ring_sec >= RSEC_W'(RING_SEC)) begin
                    state_d      = IDLE;
                    buzz_d       = 1'b0;
                    snooze_cnt_d = '0;
                end else begin
                    if (sec_tick)
                        ring_sec_d = ring_sec + RSEC_W'(1);
                    if (beep_cnt == BEEP_W'(BEEP_DIV - 1)) begin
                        beep_cnt_d = '0;
                        buzz_d     = ~buzz;
                    end else begin
                        beep_cnt_d = beep_cnt + BEEP_W'(1);
                    end
                end
            end
            SNOOZE: begin
                buzz_d = 1'b0;
                if (!alarm_en || stop_p) begin
                    state_d      = IDLE;
                    snooze_cnt_d = '0;
                end else if (min_evt) begin
                    // the minute step that empties min_left re-rings immediately
                    if (min_left <= MIN_W'(1)) begin
                        state_d    = RING;
                        min_left_d = '0;
                        ring_sec_d = '0;
                        beep_cnt_d = '0;
                        buzz_d     = 1'b1;
                    end else begin
                        min_left_d = min_left - MIN_W'(1);
                    end
                end
            end
            default: begin
                state_d      = IDLE;
                buzz_d       = 1'b0;
                snooze_cnt_d = '0;
            end
        endcase
    end
endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
Consumer end of the clock block's time interface. Watches the BCD clock value (HH:MM) and the stored alarm value, and fires the alarm when the clock rolls onto the alarm minute. Runs a ring/snooze state machine driven by the stop and snooze buttons, with a ring timeout and a snooze limit. Produces the buzzer drive and the status LEDs for the top level.

Parameters:
TICK_DIV, 100000000, clk cycles per 1 s tick; the bench uses a small value such as 10.
BEEP_DIV, 12500000, clk cycles per buzz half-period; the bench uses a small value such as 2.
RING_SEC, 60, seconds of ringing before auto-stop.
SNOOZE_MIN, 5, minutes spent snoozing before re-ring.
MAX_SNOOZE, 3, number of snoozes allowed per alarm event.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
clock_in  input  16  BCD time {HR1,HR0,MIN1,MIN0}, from the clock block's clock_out
alarm_in  input  16  BCD alarm time, same packing, from alarm_out
alarm_en  input  1  alarm arm switch (level)
clock_load  input  1  clock is being loaded; suppresses minute and match events
stop_btn  input  1  stop button (raw level)
snooze_btn  input  1  snooze button (raw level)
buzz  output  1  buzzer drive
ringing  output  1  high in RING
snoozing  output  1  high in SNOOZE
snooze_cnt  output  2  snoozes used in the current event

Behaviour:
- Reset (rst=0, async): state IDLE; buzz=0, ringing=0, snoozing=0, snooze_cnt=0.
- Reset also clears the tick, beep and ring counters, the minute counter and clock_q.
- Reset loads clock_q with clock_in on the first clk edge after release, so no event fires at reset exit.
- Buttons: 2-flop synchronizer, then rising-edge detect, giving 1-cycle pulses stop_p and snooze_p. Each press is acted on exactly once.
- clock_q: registered copy of clock_in, updated every cycle.
- min_evt = (clock_in != clock_q) && !clock_load.
- match_evt = min_evt && (clock_in == alarm_in) && alarm_en.
- Any clock_in change while clock_load=1 is ignored for both events.
- Tick: a counter in 0..TICK_DIV-1 produces a 1-cycle sec_tick on wrap. It free-runs in all states.
- IDLE:
  - match_evt -> RING; clear ring_sec and the beep phase; snooze_cnt stays 0.
- RING:
  - ringing=1.
  - buzz toggles every BEEP_DIV cycles and starts at 1 on entry.
  - ring_sec increments on sec_tick.
  - Exit priority, highest first: alarm_en=0 -> IDLE; stop_p -> IDLE; snooze_p with snooze_cnt<MAX_SNOOZE -> SNOOZE and snooze_cnt+1; ring_sec reaching RING_SEC -> IDLE.
  - snooze_p when snooze_cnt==MAX_SNOOZE is ignored; ringing continues.
  - stop_p and snooze_p in the same cycle: stop wins.
  - A match_evt while in RING is ignored.
- SNOOZE:
  - snoozing=1, buzz=0.
  - min_left is loaded with SNOOZE_MIN on entry and decrements on each min_evt.
  - min_left reaching 0 -> RING; ring_sec restarts at 0; snooze_cnt is kept.
  - stop_p or alarm_en=0 -> IDLE.
  - snooze_p is ignored.
  - A match_evt is ignored, e.g. when the alarm is edited to the current time.
- On entry to IDLE from any state: buzz=0 and snooze_cnt=0, both registered on that transition.
- All outputs are registered, so state-visible outputs lag the triggering input by 1 clk.
- RING is entered 1 clk after the clock_in change that makes clock_in equal alarm_in.
- Stopping during the matching minute does not re-ring, because match_evt requires a change of clock_in.
- The 23:59 -> 00:00 rollover is an ordinary minute event. Alarm 00:00 fires on it.
- Alarm values above 23:59 never match a legal clock value. No special handling is required.
- Counter widths: tick sized by $clog2(TICK_DIV). ring_sec, min_left and snooze_cnt saturate and never wrap.

Test Plan:
- alarm_en=1, alarm_in=16'h0700, clock_in steps 06:59 -> 07:00 -> ringing=1 one clk after the step, buzz toggling every BEEP_DIV cycles; pulse stop_btn -> IDLE, buzz=0. Hold clock_in at 07:00 -> no re-ring.
- Ring with no buttons, RING_SEC=3, TICK_DIV=10 -> ringing falls 30±10 clk after entry; snooze_cnt=0.
- Ring, press snooze -> snoozing=1, snooze_cnt=1; step clock_in by 5 minutes -> RING on the 5th step. Repeat until snooze_cnt=3; a 4th snooze press is ignored (ringing stays 1).
- clock_load=1 while clock_in is driven to equal alarm_in -> no ring. After clock_load drops, the next minute step away from the match -> no ring.
- Stop and snooze rising edges in the same cycle during RING -> IDLE, snooze_cnt=0. Deassert alarm_en during SNOOZE -> IDLE.
- Assert rst low mid-RING, asynchronously between edges -> buzz/ringing=0 immediately. Release with clock_in==alarm_in -> no ring. Alarm 00:00 with clock 23:59 -> 00:00 -> ringing=1.
